// File: rtl/excess3_to_bcd_serial_pkg.sv
// x3b_pkg: shared types and constants for the serial Excess-3 to BCD decoder.
//   x3b_state_e  : bit position / borrow FSM encoding (7 states, 3 bits)
//   EXCESS       : the constant subtracted from each Excess-3 digit
//   X3_MAX_VALID : largest legal raw Excess-3 code
//   state_pos / state_borrow : decode a state into bit index and carried borrow
package x3b_pkg;

  typedef enum logic [2:0] {
    T0    = 3'd0,
    T1_B0 = 3'd1,
    T1_B1 = 3'd2,
    T2_B0 = 3'd3,
    T2_B1 = 3'd4,
    T3_B0 = 3'd5,
    T3_B1 = 3'd6
  } x3b_state_e;

  localparam logic [3:0] EXCESS       = 4'd3;
  localparam logic [3:0] X3_MAX_VALID = 4'd12;

  function automatic logic [1:0] state_pos(input x3b_state_e s);
    case (s)
      T1_B0, T1_B1: return 2'd1;
      T2_B0, T2_B1: return 2'd2;
      T3_B0, T3_B1: return 2'd3;
      default:      return 2'd0;
    endcase
  endfunction

  function automatic logic state_borrow(input x3b_state_e s);
    case (s)
      T1_B1, T2_B1, T3_B1: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/excess3_to_bcd_serial_if.sv
// Serial Excess-3 in / decoded BCD out bundle.
//   master : producer of E_* bits and consumer of decoded results
//   slave  : the decoder
interface excess3_to_bcd_serial_if #(parameter int CNT_W = 8);
  logic             E_in;
  logic             E_valid;
  logic             E_sync;
  logic             B_out;
  logic             B_valid;
  logic             digit_last;
  logic [3:0]       digit_q;
  logic             digit_stb;
  logic             code_err;
  logic [CNT_W-1:0] digit_cnt;

  modport master (
    output E_in, E_valid, E_sync,
    input  B_out, B_valid, digit_last, digit_q, digit_stb, code_err, digit_cnt
  );

  modport slave (
    input  E_in, E_valid, E_sync,
    output B_out, B_valid, digit_last, digit_q, digit_stb, code_err, digit_cnt
  );
endinterface

// File: rtl/excess3_to_bcd_serial_sub_cell.sv
// serial_sub_cell: 1-bit full subtractor, d = e - y - b_in.
//   e, y, b_in : minuend bit, subtrahend bit, incoming borrow
//   d, b_out   : difference bit, outgoing borrow
module serial_sub_cell (
  input  logic e,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);
  assign d     = e ^ y ^ b_in;
  assign b_out = (~e & (y | b_in)) | (y & b_in);
endmodule

// File: rtl/excess3_to_bcd_serial.sv
// excess3_to_bcd_serial: LSB-first serial Excess-3 to BCD decoder (Mealy),
// with a registered parallel digit, strobe, digit counter and optional
// invalid-code flag (built only when X3B_ERR_CHECK_EN is defined).
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of excess3_to_bcd_serial_if
//                E_in/E_valid/E_sync in; B_out/B_valid/digit_last comb out;
//                digit_q/digit_stb/code_err/digit_cnt registered out
module excess3_to_bcd_serial
  import x3b_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  excess3_to_bcd_serial_if.slave    bus
);

  x3b_state_e       state_q, state_d;
  logic [1:0]       pos;
  logic             b_cur, y, d, b_nxt;
  logic [2:0]       shift_q;
  logic [3:0]       digit_q;
  logic             stb_q;
  logic [CNT_W-1:0] cnt_q;

  // A sync bit restarts the digit: decode as bit 0 with no borrow.
  always_comb begin
    pos   = state_pos(state_q);
    b_cur = state_borrow(state_q);
    if (bus.E_sync) begin
      pos   = 2'd0;
      b_cur = 1'b0;
    end
  end

  assign y = EXCESS[pos];

  serial_sub_cell u_cell (
    .e    (bus.E_in),
    .y    (y),
    .b_in (b_cur),
    .d    (d),
    .b_out(b_nxt)
  );

  always_comb begin
    state_d = state_q;
    if (bus.E_valid) begin
      case (pos)
        2'd0:    state_d = b_nxt ? T1_B1 : T1_B0;
        2'd1:    state_d = b_nxt ? T2_B1 : T2_B0;
        2'd2:    state_d = b_nxt ? T3_B1 : T3_B0;
        default: state_d = T0;  // borrow out of bit 3 is not kept
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= T0;
    else       state_q <= state_d;
  end

  // Decoded bits shift in at the top so bit 0 lands in shift_q[0].
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      digit_q <= '0;
      stb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      stb_q <= 1'b0;
      if (bus.E_valid) begin
        if (pos == 2'd3) begin
          digit_q <= {d, shift_q};
          stb_q   <= 1'b1;
          cnt_q   <= cnt_q + CNT_W'(1);
        end else begin
          shift_q <= {d, shift_q[2:1]};
        end
      end
    end
  end

`ifdef X3B_ERR_CHECK_EN
  logic [2:0] shadow_q;
  logic       err_q;

  // Raw code < 3 shows up as a final borrow; raw > 12 needs the raw bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else if (bus.E_valid) begin
      if (pos == 2'd3)
        err_q <= b_nxt | ({bus.E_in, shadow_q} > X3_MAX_VALID);
      else
        shadow_q <= {bus.E_in, shadow_q[2:1]};
    end
  end

  assign bus.code_err = err_q;
`else
  assign bus.code_err = 1'b0;
`endif

  assign bus.B_out      = bus.E_valid & d;
  assign bus.B_valid    = bus.E_valid;
  assign bus.digit_last = bus.E_valid & (pos == 2'd3);
  assign bus.digit_q    = digit_q;
  assign bus.digit_stb  = stb_q;
  assign bus.digit_cnt  = cnt_q;

endmodule

// File: tb/tb_excess3_to_bcd_serial.sv
module tb_excess3_to_bcd_serial;

  typedef struct {
    logic [3:0] q;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  logic [7:0] cnt_model = '0;

  always #5 clk = ~clk;

  excess3_to_bcd_serial_if #(.CNT_W(8)) x ();
  excess3_to_bcd_serial_if #(.CNT_W(2)) x2 ();

  assign x2.E_in    = x.E_in;
  assign x2.E_valid = x.E_valid;
  assign x2.E_sync  = x.E_sync;

  excess3_to_bcd_serial #(.CNT_W(8)) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (x.slave)
  );

  excess3_to_bcd_serial #(.CNT_W(2)) dut2 (
    .clk  (clk),
    .reset(rst),
    .bus  (x2.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [3:0] raw);
`ifdef X3B_ERR_CHECK_EN
    return (raw < 4'd3) || (raw > 4'd12);
`else
    return 1'b0;
`endif
  endfunction

  task automatic push(input logic [3:0] raw);
    exp_t e;
    cnt_model = cnt_model + 8'd1;
    e.q   = raw - 4'd3;
    e.err = exp_err(raw);
    e.cnt = cnt_model;
    sb.push_back(e);
  endtask

  // Drive bits [first, first+n) of raw; B_out is the same bit of raw-3.
  task automatic send_code(input logic [3:0] raw, input int first, input int n, input logic sync);
    logic [3:0] dd;
    dd = raw - 4'd3;
    for (int i = first; i < first + n; i++) begin
      @(negedge clk);
      x.E_in    = raw[i];
      x.E_valid = 1'b1;
      x.E_sync  = sync && (i == first);
      #1;
      chk("B_out", 32'(x.B_out), 32'(dd[i]));
      chk("B_valid", 32'(x.B_valid), 32'd1);
      chk("digit_last", 32'(x.digit_last), (i == 3) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      x.E_valid = 1'b0;
      x.E_in    = 1'($urandom);
      x.E_sync  = 1'($urandom);
      #1;
      chk("B_out_idle", 32'(x.B_out), 32'd0);
      chk("last_idle", 32'(x.digit_last), 32'd0);
    end
  endtask

  // Scoreboard drain: every strobe must match the oldest pushed digit.
  always @(negedge clk) begin
    if (rst === 1'b0 && x.digit_stb === 1'b1) begin
      if (sb.size() == 0) begin
        chk("stb_unexpected", 32'(x.digit_stb), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("digit_q", 32'(x.digit_q), 32'(e.q));
        chk("code_err", 32'(x.code_err), 32'(e.err));
        chk("digit_cnt", 32'(x.digit_cnt), 32'(e.cnt));
        chk("cnt_w2", 32'(x2.digit_cnt), 32'(e.cnt[1:0]));
        chk("stb_w2", 32'(x2.digit_stb), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] r;
    rst = 1'b1;
    x.E_in = 1'b0; x.E_valid = 1'b0; x.E_sync = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_digit_q", 32'(x.digit_q), 32'd0);
    chk("rst_stb", 32'(x.digit_stb), 32'd0);
    chk("rst_err", 32'(x.code_err), 32'd0);
    chk("rst_cnt", 32'(x.digit_cnt), 32'd0);
    chk("rst_B_out", 32'(x.B_out), 32'd0);
    rst = 1'b0;

    // 1100 -> 1001
    push(4'd12); send_code(4'd12, 0, 4, 1'b0);
    // back-to-back 0011 -> 0000, 1000 -> 0101
    push(4'd3);  send_code(4'd3, 0, 4, 1'b0);
    push(4'd8);  send_code(4'd8, 0, 4, 1'b0);
    // invalid codes: 0010 -> 1111, 1101 -> 1010
    push(4'd2);  send_code(4'd2, 0, 4, 1'b0);
    push(4'd13); send_code(4'd13, 0, 4, 1'b0);
    idle(2);

    // gap in the middle of a digit
    push(4'd7);
    send_code(4'd7, 0, 2, 1'b0);
    idle(5);
    send_code(4'd7, 2, 2, 1'b0);

    // resync drops the partial digit
    send_code(4'd5, 0, 2, 1'b0);
    push(4'd12); send_code(4'd12, 0, 4, 1'b1);
    idle(2);

    // reset after bit 2, with E_valid still high to show reset wins
    send_code(4'd9, 0, 3, 1'b0);
    @(negedge clk);
    rst = 1'b1; x.E_valid = 1'b1; x.E_in = 1'b1; x.E_sync = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_digit_q", 32'(x.digit_q), 32'd0);
    chk("mid_rst_stb", 32'(x.digit_stb), 32'd0);
    chk("mid_rst_err", 32'(x.code_err), 32'd0);
    chk("mid_rst_cnt", 32'(x.digit_cnt), 32'd0);
    chk("mid_rst_cnt2", 32'(x2.digit_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0; x.E_valid = 1'b0;
    #1;
    chk("post_rst_B_out", 32'(x.B_out), 32'd0);
    cnt_model = '0;
    push(4'd6); send_code(4'd6, 0, 4, 1'b0);

    // more digits so the 2-bit counter wraps 1,2,3,0,1...
    for (int k = 0; k < 5; k++) begin
      r = 4'($urandom_range(0, 15));
      push(r); send_code(r, 0, 4, 1'b0);
    end
    idle(3);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
